// File: rtl/dma_burst_writer_if.sv
// ============================================================================
// Module   : dma_burst_writer_if
// Purpose  : AXI3 write-channel bundle (AW/W/B) between burst master and HP0.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface dma_burst_writer_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64
);
  logic [ADDR_W-1:0]   awaddr;
  logic                awvalid;
  logic                awready;
  logic [3:0]          awlen;
  logic [2:0]          awsize;
  logic [1:0]          awburst;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wlast;
  logic                wvalid;
  logic                wready;
  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;

  modport master (
    output awaddr, awvalid, awlen, awsize, awburst,
    output wdata, wstrb, wlast, wvalid, bready,
    input  awready, wready, bresp, bvalid
  );

  modport slave (
    input  awaddr, awvalid, awlen, awsize, awburst,
    input  wdata, wstrb, wlast, wvalid, bready,
    output awready, wready, bresp, bvalid
  );
endinterface

`default_nettype wire

// File: rtl/dma_burst_writer.sv
// ============================================================================
// Module   : dma_burst_writer
// Purpose  : AXI3 INCR burst write master streaming samples into a DDR region.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module dma_burst_writer #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 64,
  parameter int BURST_BEATS = 16,
  parameter int CNT_W       = 24,
  parameter int STOP_ON_ERR = 0
) (
  input  wire logic              aclk,
  input  wire logic              rst_i,
  input  wire logic              start_i,
  input  wire logic              abort_i,
  input  wire logic              ring_i,
  input  wire logic [ADDR_W-1:0] base_addr_i,
  input  wire logic [ADDR_W-1:0] size_bytes_i,
  input  wire logic [DATA_W-1:0] s_data_i,
  input  wire logic              s_valid_i,
  output logic                   s_ready_o,
  dma_burst_writer_if.master     m_axi,
  output logic                   busy_o,
  output logic                   done_o,
  output logic                   aborted_o,
  output logic                   error_o,
  output logic                   cfg_err_o,
  output logic                   wrap_o,
  output logic [CNT_W-1:0]       bursts_o,
  output logic [CNT_W-1:0]       errors_o
);

  localparam int BYTES       = DATA_W / 8;
  localparam int BURST_BYTES = BURST_BEATS * BYTES;
  localparam int OFF_W       = $clog2(BURST_BYTES);
  localparam int BEAT_W      = $clog2(BURST_BEATS);
  localparam logic [ADDR_W-1:0] BURST_INC = ADDR_W'(BURST_BYTES);
  localparam logic [ADDR_W-1:0] OFF_MASK  = ADDR_W'(BURST_BYTES - 1);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_BEATS - 1);

  generate
    if (BURST_BYTES > 4096) begin : g_bad_burst
      $error("dma_burst_writer: a burst must not cross a 4 KiB boundary");
    end
  endgenerate

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ADDR  = 3'd1,
    ST_DATA  = 3'd2,
    ST_RESP  = 3'd3,
    ST_DONE  = 3'd4,
    ST_ERROR = 3'd5
  } state_t;

  state_t             state, state_n;
  logic               start_q;
  logic [ADDR_W-1:0]  base, nbursts, addr, idx;
  logic               ring;
  logic [BEAT_W-1:0]  beat;

  logic               start_edge, w_hs, last_beat, b_ok, stop_err, last_burst;
  logic [ADDR_W-1:0]  nb_in, base_in, idx_next;

  assign start_edge = start_i & ~start_q;
  assign nb_in      = size_bytes_i >> OFF_W;
  assign base_in    = base_addr_i & ~OFF_MASK;
  assign last_beat  = (beat == LAST_BEAT);
  assign w_hs       = (state == ST_DATA) && s_valid_i && m_axi.wready;
  assign b_ok       = (m_axi.bresp == 2'b00);
  assign stop_err   = !b_ok && (STOP_ON_ERR != 0);
  assign idx_next   = idx + ADDR_W'(1);
  assign last_burst = (idx_next == nbursts);

  assign m_axi.awlen   = 4'(BURST_BEATS - 1);
  assign m_axi.awsize  = 3'($clog2(BYTES));
  assign m_axi.awburst = 2'b01;
  assign m_axi.wstrb   = '1;
  assign m_axi.awaddr  = addr;

  always_ff @(posedge aclk or posedge rst_i) begin
    if (rst_i) state <= ST_IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n         = state;
    m_axi.awvalid   = 1'b0;
    m_axi.wvalid    = 1'b0;
    m_axi.wdata     = '0;
    m_axi.wlast     = 1'b0;
    m_axi.bready    = 1'b0;
    s_ready_o       = 1'b0;
    busy_o          = 1'b0;
    done_o          = 1'b0;
    case (state)
      ST_IDLE, ST_ERROR: begin
        if (start_edge) state_n = (nb_in == '0) ? ST_DONE : ST_ADDR;
      end
      ST_DONE: begin
        done_o = 1'b1;
        if (start_edge) state_n = (nb_in == '0) ? ST_DONE : ST_ADDR;
      end
      ST_ADDR: begin
        busy_o        = 1'b1;
        m_axi.awvalid = 1'b1;
        if (m_axi.awready) state_n = ST_DATA;
      end
      ST_DATA: begin
        busy_o       = 1'b1;
        m_axi.wvalid = s_valid_i;
        m_axi.wdata  = s_data_i;
        m_axi.wlast  = last_beat;
        s_ready_o    = m_axi.wready;
        if (w_hs && last_beat) state_n = ST_RESP;
      end
      ST_RESP: begin
        busy_o       = 1'b1;
        m_axi.bready = 1'b1;
        if (m_axi.bvalid) begin
          if (stop_err)        state_n = ST_ERROR;
          else if (abort_i)    state_n = ST_DONE;
          else if (last_burst) state_n = ring ? ST_ADDR : ST_DONE;
          else                 state_n = ST_ADDR;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge aclk or posedge rst_i) begin
    if (rst_i) begin
      start_q   <= 1'b0;
      base      <= '0;
      nbursts   <= '0;
      ring      <= 1'b0;
      addr      <= '0;
      idx       <= '0;
      beat      <= '0;
      bursts_o  <= '0;
      errors_o  <= '0;
      aborted_o <= 1'b0;
      error_o   <= 1'b0;
      cfg_err_o <= 1'b0;
      wrap_o    <= 1'b0;
    end else begin
      start_q <= start_i;
      wrap_o  <= 1'b0;
      case (state)
        ST_IDLE, ST_DONE, ST_ERROR: begin
          if (start_edge) begin
            base      <= base_in;
            nbursts   <= nb_in;
            ring      <= ring_i;
            addr      <= base_in;
            idx       <= '0;
            bursts_o  <= '0;
            errors_o  <= '0;
            aborted_o <= 1'b0;
            error_o   <= 1'b0;
            cfg_err_o <= (nb_in == '0);
          end
        end
        ST_ADDR: begin
          if (m_axi.awready) beat <= '0;
        end
        ST_DATA: begin
          if (w_hs) beat <= beat + BEAT_W'(1);
        end
        ST_RESP: begin
          if (m_axi.bvalid) begin
            if (b_ok) begin
              if (bursts_o != '1) bursts_o <= bursts_o + CNT_W'(1);
            end else begin
              if (errors_o != '1) errors_o <= errors_o + CNT_W'(1);
              error_o <= 1'b1;
            end
            // A failed burst is not replayed: its data has already left the stream.
            if (!stop_err) begin
              if (abort_i) begin
                aborted_o <= 1'b1;
              end else if (last_burst && ring) begin
                addr   <= base;
                idx    <= '0;
                wrap_o <= 1'b1;
              end else begin
                addr <= addr + BURST_INC;
                idx  <= idx_next;
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_dma_burst_writer.sv
// ============================================================================
// Module   : tb_dma_burst_writer
// Purpose  : Scoreboard bench for dma_burst_writer with an AXI slave model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dma_burst_writer;

  logic aclk = 1'b0;
  always #5 aclk = ~aclk;

  logic        rst_i = 1'b1;
  logic        start_i = 1'b0, abort_i = 1'b0, ring_i = 1'b0;
  logic [31:0] base_addr_i = '0, size_bytes_i = '0;
  logic [63:0] s_data_i = '0;
  logic        s_valid_i = 1'b0, s_ready_o;
  logic        busy_o, done_o, aborted_o, error_o, cfg_err_o, wrap_o;
  logic [23:0] bursts_o, errors_o;

  logic        start2 = 1'b0, s_valid2 = 1'b0, s_ready2;
  logic [63:0] s_data2 = '0;
  logic        busy2, done2, aborted2, error2, cfg_err2, wrap2;
  logic [23:0] bursts2, errors2;
  logic        abort2 = 1'b0, ring2 = 1'b0;

  dma_burst_writer_if #(.ADDR_W(32), .DATA_W(64)) ax ();
  dma_burst_writer_if #(.ADDR_W(32), .DATA_W(64)) ax2 ();

  dma_burst_writer #(.ADDR_W(32), .DATA_W(64), .BURST_BEATS(16), .CNT_W(24), .STOP_ON_ERR(0)) dut (
    .aclk(aclk), .rst_i(rst_i), .start_i(start_i), .abort_i(abort_i), .ring_i(ring_i),
    .base_addr_i(base_addr_i), .size_bytes_i(size_bytes_i),
    .s_data_i(s_data_i), .s_valid_i(s_valid_i), .s_ready_o(s_ready_o), .m_axi(ax),
    .busy_o(busy_o), .done_o(done_o), .aborted_o(aborted_o), .error_o(error_o),
    .cfg_err_o(cfg_err_o), .wrap_o(wrap_o), .bursts_o(bursts_o), .errors_o(errors_o)
  );

  dma_burst_writer #(.ADDR_W(32), .DATA_W(64), .BURST_BEATS(16), .CNT_W(24), .STOP_ON_ERR(1)) dut2 (
    .aclk(aclk), .rst_i(rst_i), .start_i(start2), .abort_i(abort2), .ring_i(ring2),
    .base_addr_i(base_addr_i), .size_bytes_i(size_bytes_i),
    .s_data_i(s_data2), .s_valid_i(s_valid2), .s_ready_o(s_ready2), .m_axi(ax2),
    .busy_o(busy2), .done_o(done2), .aborted_o(aborted2), .error_o(error2),
    .cfg_err_o(cfg_err2), .wrap_o(wrap2), .bursts_o(bursts2), .errors_o(errors2)
  );

  int checks = 0, n_err = 0;
  int cyc = 0;
  bit pat = 0;
  int err_burst = 0;
  int bnum = 0, bpend = 0, aw_cnt = 0, wrap_cnt = 0;
  logic [31:0] scnt = '0;
  bit aw_wait = 0;
  int bnum2 = 0, bpend2 = 0, aw2_cnt = 0;
  logic [31:0] exp_aw[$];
  logic [64:0] exp_w[$];

  function automatic logic [63:0] pat_data(input logic [31:0] n);
    return {~n, n};
  endfunction

  task automatic check(input string name, input logic [64:0] act, input logic [64:0] exp);
    checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Slave/source model: drive on the falling edge, observe handshakes just before the rising edge.
  always @(negedge aclk) begin
    cyc++;
    s_valid_i  = pat ? cyc[0] : 1'b1;
    s_data_i   = pat_data(scnt);
    ax.awready = pat ? (cyc % 4 != 0) : 1'b1;
    ax.wready  = pat ? (cyc % 3 != 0) : 1'b1;
    ax.bvalid  = (bpend > 0);
    ax.bresp   = (bnum + 1 == err_burst) ? 2'b10 : 2'b00;
    s_valid2    = 1'b1;
    ax2.awready = 1'b1;
    ax2.wready  = 1'b1;
    ax2.bvalid  = (bpend2 > 0);
    ax2.bresp   = (bnum2 == 2) ? 2'b10 : 2'b00;
    #4;
    if (rst_i) begin
      aw_wait = 0;
    end else begin
      if (aw_wait) check("aw_hold", ax.awvalid, 1);
      aw_wait = ax.awvalid && !ax.awready;
      if (ax.awvalid && ax.awready) begin
        aw_cnt++;
        if (exp_aw.size() == 0) check("aw_expected", exp_aw.size() != 0, 1);
        else check("awaddr", ax.awaddr, exp_aw.pop_front());
      end
      if (ax.wvalid) check("wvalid_src", s_valid_i, 1);
      if (ax.wvalid && ax.wready) begin
        if (exp_w.size() == 0) check("w_expected", exp_w.size() != 0, 1);
        else check("wbeat", {ax.wlast, ax.wdata}, exp_w.pop_front());
        scnt++;
        if (ax.wlast) bpend++;
      end
      if (ax.bvalid && ax.bready) begin
        bpend--;
        bnum++;
      end
      if (wrap_o) wrap_cnt++;
      if (ax2.awvalid && ax2.awready) aw2_cnt++;
      if (ax2.wvalid && ax2.wready && ax2.wlast) bpend2++;
      if (ax2.bvalid && ax2.bready) begin
        bpend2--;
        bnum2++;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge aclk);
    #2;
  endtask

  task automatic expect_bursts(input logic [31:0] b, input int n, input int nb);
    for (int i = 0; i < n; i++) exp_aw.push_back(b + 32'((i % nb) * 128));
    for (int k = 0; k < n * 16; k++) exp_w.push_back({(k % 16) == 15, pat_data(32'(k))});
  endtask

  task automatic launch(input logic [31:0] b, input logic [31:0] sz, input bit rg);
    base_addr_i = b; size_bytes_i = sz; ring_i = rg;
    bnum = 0; bpend = 0; scnt = 0; aw_cnt = 0; wrap_cnt = 0;
    start_i = 1'b1;
    tick(1);
    start_i = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (!done_o && n < 3000) begin tick(1); n++; end
    check({name, "_done"}, done_o, 1);
  endtask

  task automatic wait_aw(input int target);
    int n = 0;
    while (aw_cnt < target && n < 3000) begin tick(1); n++; end
    check("wait_aw", aw_cnt >= target, 1);
  endtask

  task automatic check_idle_outputs(input string name);
    check({name, "_busy"}, busy_o, 0);
    check({name, "_done"}, done_o, 0);
    check({name, "_awvalid"}, ax.awvalid, 0);
    check({name, "_wvalid"}, ax.wvalid, 0);
    check({name, "_wlast"}, ax.wlast, 0);
    check({name, "_wdata"}, ax.wdata, 0);
    check({name, "_awaddr"}, ax.awaddr, 0);
    check({name, "_bready"}, ax.bready, 0);
    check({name, "_sready"}, s_ready_o, 0);
    check({name, "_flags"}, {aborted_o, error_o, cfg_err_o, wrap_o}, 0);
    check({name, "_bursts"}, bursts_o, 0);
    check({name, "_errors"}, errors_o, 0);
    check({name, "_consts"}, {ax.awlen, ax.awsize, ax.awburst, ax.wstrb}, {4'hF, 3'd3, 2'b01, 8'hFF});
  endtask

  task automatic check_clean_run(input string name, input int nb);
    check({name, "_bursts"}, bursts_o, 24'(nb));
    check({name, "_errors"}, errors_o, 0);
    check({name, "_aw_cnt"}, aw_cnt, nb);
    check({name, "_flags"}, {aborted_o, error_o, cfg_err_o, busy_o}, 0);
    check({name, "_aw_left"}, exp_aw.size(), 0);
    check({name, "_w_left"}, exp_w.size(), 0);
    check({name, "_wraps"}, wrap_cnt, 0);
  endtask

  initial begin
    tick(3);
    check_idle_outputs("reset");
    rst_i = 1'b0;
    tick(2);

    // One-shot 8 bursts, with a start edge issued while busy.
    expect_bursts(32'h1000_0000, 8, 8);
    launch(32'h1000_0000, 32'h400, 0);
    wait_aw(3);
    start_i = 1'b1;
    tick(1);
    start_i = 1'b0;
    wait_done("oneshot");
    check_clean_run("oneshot", 8);

    // Back-pressure and a gappy source.
    pat = 1;
    expect_bursts(32'h1000_0000, 8, 8);
    launch(32'h1000_0000, 32'h400, 0);
    wait_done("stall");
    pat = 0;
    check_clean_run("stall", 8);

    // SLVERR on burst 3, counted and skipped.
    err_burst = 3;
    expect_bursts(32'h1000_0000, 8, 8);
    launch(32'h1000_0000, 32'h400, 0);
    wait_done("slverr");
    err_burst = 0;
    check("slverr_bursts", bursts_o, 7);
    check("slverr_errors", errors_o, 1);
    check("slverr_flag", error_o, 1);
    check("slverr_aw_left", exp_aw.size(), 0);

    // Ring of 4 bursts, abort during burst 6.
    expect_bursts(32'h1000_0000, 6, 4);
    launch(32'h1000_0000, 32'h200, 1);
    wait_aw(6);
    abort_i = 1'b1;
    wait_done("ring");
    check("ring_aborted", aborted_o, 1);
    check("ring_bursts", bursts_o, 6);
    check("ring_wraps", wrap_cnt, 1);
    check("ring_aw_cnt", aw_cnt, 6);
    check("ring_w_left", exp_w.size(), 0);
    tick(10);
    check("abort_in_done", {done_o, busy_o}, 2'b10);
    check("abort_in_done_aw", aw_cnt, 6);
    abort_i = 1'b0;

    // Region smaller than one burst.
    launch(32'h1000_0047, 32'h7F, 0);
    wait_done("cfg");
    tick(5);
    check("cfg_err", cfg_err_o, 1);
    check("cfg_aw_cnt", aw_cnt, 0);
    check("cfg_bursts", bursts_o, 0);

    // Reset in the middle of a data phase, then a clean rerun.
    expect_bursts(32'h1000_0000, 8, 8);
    launch(32'h1000_0000, 32'h400, 0);
    wait_aw(2);
    tick(3);
    check("pre_rst_busy", busy_o, 1);
    rst_i = 1'b1;
    #1;
    check_idle_outputs("midrst");
    exp_aw.delete();
    exp_w.delete();
    bpend = 0;
    tick(2);
    rst_i = 1'b0;
    tick(2);
    expect_bursts(32'h1000_0000, 8, 8);
    launch(32'h1000_0000, 32'h400, 0);
    wait_done("rerun");
    check_clean_run("rerun", 8);

    // STOP_ON_ERR=1 instance: SLVERR on burst 3 stops in the error state.
    base_addr_i = 32'h1000_0000; size_bytes_i = 32'h400;
    bnum2 = 0; bpend2 = 0; aw2_cnt = 0;
    start2 = 1'b1;
    tick(1);
    start2 = 1'b0;
    begin
      int n = 0;
      while (!(error2 && !busy2) && n < 3000) begin tick(1); n++; end
    end
    tick(5);
    check("stop_busy_done", {busy2, done2}, 0);
    check("stop_error", error2, 1);
    check("stop_bursts", bursts2, 2);
    check("stop_errors", errors2, 1);
    check("stop_aw_cnt", aw2_cnt, 3);

    $display("Simulation finished: %0d checks, %0d errors", checks, n_err);
    $finish;
  end

endmodule

`default_nettype wire
